// File: rtl/test_sequencer.sv
// Test-run controller: launches NUM_TESTS self-test channels (parallel or one at a time),
// captures sticky per-channel fails, the first failing index, run length and watchdog expiry.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// RUN    | channels enabled, collecting results, watchdog running
// FINISH | results held, done high, start relaunches
module test_sequencer #(
  parameter int NUM_TESTS      = 3,
  parameter bit SEQUENTIAL     = 1'b0,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16,
  localparam int IDX_W         = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_TESTS-1:0] test_done,
  input  logic [NUM_TESTS-1:0] test_result,
  output logic [NUM_TESTS-1:0] test_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [IDX_W-1:0]     first_fail,
  output logic                 first_fail_valid,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_count
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [IDX_W-1:0]     idx;
  logic [WD_W-1:0]      wdog;
  logic [NUM_TESTS-1:0] hit;
  logic [IDX_W-1:0]     low_idx;
  logic                 chan_done, last_chan;
  logic                 launch, complete, expire, advance;

  assign hit       = test_enable & test_result;
  assign chan_done = SEQUENTIAL ? test_done[idx] : &test_done;
  assign last_chan = SEQUENTIAL ? (idx == LAST_IDX) : 1'b1;

  // Lowest newly failing channel wins when several fail together
  always_comb begin
    low_idx = '0;
    for (int i = NUM_TESTS - 1; i >= 0; i--) begin
      if (hit[i]) low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    complete = 1'b0;
    expire   = 1'b0;
    advance  = 1'b0;
    case (state)
      S_IDLE, S_FINISH: begin
        if (start) begin
          state_nx = S_RUN;
          launch   = 1'b1;
        end
      end
      S_RUN: begin
        // Completion is checked before the watchdog so a coincident finish is not a timeout
        if (chan_done) begin
          if (last_chan) begin
            state_nx = S_FINISH;
            complete = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end else if (wdog == WD_LAST) begin
          state_nx = S_FINISH;
          expire   = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      test_enable      <= '0;
      fail_mask        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      timeout          <= 1'b0;
      cycle_count      <= '0;
      idx              <= '0;
      wdog             <= '0;
    end else if (launch) begin
      test_enable      <= SEQUENTIAL ? NUM_TESTS'(1) : '1;
      fail_mask        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      timeout          <= 1'b0;
      cycle_count      <= '0;
      idx              <= '0;
      wdog             <= '0;
    end else if (state == S_RUN) begin
      if (cycle_count != {CNT_W{1'b1}}) cycle_count <= cycle_count + CNT_W'(1);
      wdog      <= wdog + WD_W'(1);
      fail_mask <= fail_mask | hit;
      if (!first_fail_valid && (|hit)) begin
        first_fail_valid <= 1'b1;
        first_fail       <= low_idx;
      end
      if (complete || expire) test_enable <= '0;
      if (expire) timeout <= 1'b1;
      if (advance) begin
        test_enable <= test_enable << 1;
        idx         <= idx + IDX_W'(1);
        wdog        <= '0;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_FINISH);
  assign fail = done & ((|fail_mask) | timeout);

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: a parallel instance and a sequential instance (TIMEOUT_CYCLES=10)
// driven by a small channel emulator from a table of runs plus reset and trace sequences.
module tb_test_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start_p = 1'b0, start_s = 1'b0;
  logic [2:0] tdone_p = '0, tdone_s = '0, tres_p = '0, tres_s = '0;
  logic [2:0] en_p, en_s, mask_p, mask_s;
  logic       busy_p, busy_s, done_p, done_s, fail_p, fail_s;
  logic [1:0] ff_p, ff_s;
  logic       ffv_p, ffv_s, tmo_p, tmo_s;
  logic [15:0] cnt_p, cnt_s;

  test_sequencer #(.NUM_TESTS(3), .SEQUENTIAL(1'b0), .TIMEOUT_CYCLES(1000), .CNT_W(16)) dut_par (
    .clk(clk), .reset(reset), .start(start_p), .test_done(tdone_p), .test_result(tres_p),
    .test_enable(en_p), .busy(busy_p), .done(done_p), .fail(fail_p), .fail_mask(mask_p),
    .first_fail(ff_p), .first_fail_valid(ffv_p), .timeout(tmo_p), .cycle_count(cnt_p));

  test_sequencer #(.NUM_TESTS(3), .SEQUENTIAL(1'b1), .TIMEOUT_CYCLES(10), .CNT_W(16)) dut_seq (
    .clk(clk), .reset(reset), .start(start_s), .test_done(tdone_s), .test_result(tres_s),
    .test_enable(en_s), .busy(busy_s), .done(done_s), .fail(fail_s), .fail_mask(mask_s),
    .first_fail(ff_s), .first_fail_valid(ffv_s), .timeout(tmo_s), .cycle_count(cnt_s));

  bit sel = 1'b0;
  wire [2:0]  o_en   = sel ? en_s   : en_p;
  wire [2:0]  o_mask = sel ? mask_s : mask_p;
  wire        o_busy = sel ? busy_s : busy_p;
  wire        o_done = sel ? done_s : done_p;
  wire        o_fail = sel ? fail_s : fail_p;
  wire [1:0]  o_ff   = sel ? ff_s   : ff_p;
  wire        o_ffv  = sel ? ffv_s  : ffv_p;
  wire        o_tmo  = sel ? tmo_s  : tmo_p;
  wire [15:0] o_cnt  = sel ? cnt_s  : cnt_p;

  int checks = 0;
  int errors = 0;

  // dlat/flat: edges a channel must see enabled (counting the enabling edge) before its
  // done/result rises; 0 = never, flat -1 = result stuck high even while disabled
  typedef struct {
    bit         seq;
    int         dlat [3];
    int         flat [3];
    int         exp_cnt;
    logic [2:0] exp_mask;
    logic [1:0] exp_ff;
    bit         exp_ffv;
    bit         exp_tmo;
    logic [2:0] exp_ever;
  } vec_t;

  int         age [3];
  logic [2:0] dbit, rbit, ever;
  logic [2:0] trace [0:63];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit seq, int d0, int d1, int d2, int f0, int f1, int f2,
                              int cnt, logic [2:0] mask, logic [1:0] ff, bit ffv, bit tmo,
                              logic [2:0] ev);
    vec_t v;
    v.seq = seq;
    v.dlat[0] = d0; v.dlat[1] = d1; v.dlat[2] = d2;
    v.flat[0] = f0; v.flat[1] = f1; v.flat[2] = f2;
    v.exp_cnt = cnt; v.exp_mask = mask; v.exp_ff = ff; v.exp_ffv = ffv;
    v.exp_tmo = tmo; v.exp_ever = ev;
    return v;
  endfunction

  task automatic drive(input logic [2:0] d, input logic [2:0] r);
    if (sel) begin tdone_s = d; tres_s = r; end
    else     begin tdone_p = d; tres_p = r; end
  endtask

  task automatic upd(input vec_t v);
    logic [2:0] en;
    en = o_en;
    for (int i = 0; i < 3; i++) begin
      if (en[i]) age[i]++;
      ever[i] = ever[i] | en[i];
      dbit[i] = dbit[i] | (v.dlat[i] > 0 && age[i] >= v.dlat[i]);
      rbit[i] = (v.flat[i] < 0) || (v.flat[i] > 0 && age[i] >= v.flat[i]);
    end
    drive(dbit, rbit);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"},   o_en,   0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_fail"}, o_fail, 0);
    chk({tag, "_mask"}, o_mask, 0);
    chk({tag, "_ff"},   o_ff,   0);
    chk({tag, "_ffv"},  o_ffv,  0);
    chk({tag, "_tmo"},  o_tmo,  0);
    chk({tag, "_cnt"},  o_cnt,  0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    sel = v.seq;
    for (int i = 0; i < 3; i++) age[i] = 0;
    dbit = '0; rbit = '0; ever = '0;
    @(negedge clk);
    drive('0, '0);
    if (sel) start_s = 1'b1; else start_p = 1'b1;
    @(posedge clk); #1;
    start_p = 1'b0; start_s = 1'b0;
    n = 0;
    trace[0] = o_en;
    chk({tag, "_launch_busy"}, o_busy, 1);
    chk({tag, "_launch_en"},   o_en,   v.seq ? 3'b001 : 3'b111);
    chk({tag, "_launch_mask"}, o_mask, 0);
    chk({tag, "_launch_ffv"},  o_ffv,  0);
    chk({tag, "_launch_tmo"},  o_tmo,  0);
    chk({tag, "_launch_cnt"},  o_cnt,  0);
    upd(v);
    while (!o_done && n < 60) begin
      @(posedge clk); #1;
      n++;
      trace[n] = o_en;
      upd(v);
    end
    chk({tag, "_finish_seen"}, o_done, 1);
    chk({tag, "_edges"},  n,      v.exp_cnt);
    chk({tag, "_cnt"},    o_cnt,  v.exp_cnt);
    chk({tag, "_busy"},   o_busy, 0);
    chk({tag, "_en"},     o_en,   0);
    chk({tag, "_mask"},   o_mask, v.exp_mask);
    chk({tag, "_ffv"},    o_ffv,  v.exp_ffv);
    if (v.exp_ffv) chk({tag, "_ff"}, o_ff, v.exp_ff);
    chk({tag, "_tmo"},    o_tmo,  v.exp_tmo);
    chk({tag, "_fail"},   o_fail, (|v.exp_mask) | v.exp_tmo);
    chk({tag, "_ever"},   ever,   v.exp_ever);
    // results must hold in FINISH while start stays low
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_hold_done"}, o_done, 1);
    chk({tag, "_hold_cnt"},  o_cnt,  v.exp_cnt);
  endtask

  vec_t tbl [8];

  initial begin
    // parallel: done at cycles 4,7,5 -> finish on edge 8
    tbl[0] = mk(0, 5, 8, 6, 0, 0, 0,  8, 3'b000, 2'd0, 0, 0, 3'b111);
    // parallel: ch2 fails cycle 3, ch0+ch1 cycle 5
    tbl[1] = mk(0, 8, 8, 8, 6, 6, 4,  8, 3'b111, 2'd2, 1, 0, 3'b111);
    // restart from a failed FINISH, clean run
    tbl[2] = mk(0, 5, 8, 6, 0, 0, 0,  8, 3'b000, 2'd0, 0, 0, 3'b111);
    // sequential: ch0 one cycle too slow -> watchdog, nothing else runs
    tbl[3] = mk(1, 11, 3, 3, 0, 0, 0, 10, 3'b000, 2'd0, 0, 1, 3'b001);
    // sequential: 3 cycles each, right after a timeout run
    tbl[4] = mk(1, 3, 3, 3, 0, 0, 0,  9, 3'b000, 2'd0, 0, 0, 3'b111);
    // sequential: ch1 hangs -> timeout 10 cycles after handoff
    tbl[5] = mk(1, 3, 0, 3, 0, 0, 0, 13, 3'b000, 2'd0, 0, 1, 3'b011);
    // sequential: ch0 completes on the watchdog's last cycle -> completion wins
    tbl[6] = mk(1, 10, 3, 3, 0, 0, 0, 16, 3'b000, 2'd0, 0, 0, 3'b111);
    // sequential: ch1 fails, ch2 result high while disabled must be ignored until enabled
    tbl[7] = mk(1, 3, 3, 3, 0, 2, -1, 9, 3'b110, 2'd1, 1, 0, 3'b111);

    #2;
    sel = 1'b0; chk_zero("rst_par");
    sel = 1'b1; chk_zero("rst_seq");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // sequential enable walk, one-hot handoffs on consecutive edges
    run_vec(tbl[4], "walk");
    chk("walk_e2", trace[2], 3'b001);
    chk("walk_e3", trace[3], 3'b010);
    chk("walk_e5", trace[5], 3'b010);
    chk("walk_e6", trace[6], 3'b100);
    chk("walk_e8", trace[8], 3'b100);
    chk("walk_e9", trace[9], 3'b000);

    // asynchronous reset between edges in the middle of a parallel run
    sel = 1'b0;
    @(negedge clk);
    drive('0, 3'b100);
    start_p = 1'b1;
    @(posedge clk); #1;
    start_p = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", o_busy, 1);
    chk("mid_cnt",  o_cnt,  3);
    chk("mid_mask", o_mask, 3'b100);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    drive('0, '0);
    @(posedge clk); #1;
    chk("idle_after_rst_busy", o_busy, 0);
    chk("idle_after_rst_done", o_done, 0);
    run_vec(tbl[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
